// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with one-shot and
// auto-reload modes, a terminal-count pulse and a sticky done flag.
module down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             auto_reload,
    input  logic             abort,
    input  logic             done_clr,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             busy_q, busy_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        done_d   = done_q & ~done_clr;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (load_valid) begin
                    count_d  = load_value;
                    reload_d = load_value;
                    if (load_value != '0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                        tc_d    = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (enable) begin
                    if (count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                    end else begin
                        // RUN never holds zero, so this is the step out of 1
                        tc_d   = 1'b1;
                        done_d = 1'b1;
                        if (auto_reload) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            busy_q   <= 1'b0;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            tc_q     <= tc_d;
            done_q   <= done_d;
        end
    end

    assign load_ready = (state_q != S_RUN);
    assign count      = count_q;
    assign busy       = busy_q;
    assign tc         = tc_q;
    assign done       = done_q;

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed and randomized checks of down_timer
// against a cycle-level behavioural model of the timer rules.
module tb_down_timer;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             load_valid;
    logic [WIDTH-1:0] load_value;
    logic             load_ready;
    logic             auto_reload;
    logic             abort;
    logic             done_clr;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic             done;

    int checks = 0;
    int errors = 0;

    // behavioural model of the timer
    bit               m_run;
    logic [WIDTH-1:0] m_cnt;
    logic [WIDTH-1:0] m_rel;
    bit               m_tc;
    bit               m_done;

    logic [WIDTH+3:0] act, exp;

    down_timer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready),
        .auto_reload(auto_reload),
        .abort      (abort),
        .done_clr   (done_clr),
        .count      (count),
        .busy       (busy),
        .tc         (tc),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_run  = 0;
        m_cnt  = '0;
        m_rel  = '0;
        m_tc   = 0;
        m_done = 0;
    endtask

    // One clock of the timer rules, applied to the inputs at the edge.
    task automatic model_step();
        bit nt;
        bit nd;
        nt = 0;
        nd = m_done && !done_clr;
        if (!m_run) begin
            if (load_valid) begin
                m_cnt = load_value;
                m_rel = load_value;
                if (load_value == 0) nt = 1;
                else m_run = 1;
            end
        end else if (abort) begin
            m_run = 0;
            m_cnt = '0;
        end else if (enable) begin
            if (m_cnt == 1) begin
                nt    = 1;
                m_cnt = auto_reload ? m_rel : '0;
                m_run = auto_reload;
            end else begin
                m_cnt = m_cnt - 1'b1;
            end
        end
        if (nt) nd = 1;
        m_tc   = nt;
        m_done = nd;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        act = {count, busy, tc, done, load_ready};
        exp = {m_cnt, m_run, m_tc, m_done, !m_run};
    endtask

    task automatic idle_inputs();
        enable      = 1'b0;
        load_valid  = 1'b0;
        load_value  = '0;
        auto_reload = 1'b0;
        abort       = 1'b0;
        done_clr    = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        act = {count, busy, tc, done, load_ready};
        checks++;
        if (act !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset: got %b want %b", act, 8'b0000_0001);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_oneshot();
        int tc_at;
        tc_at = -1;
        enable = 1'b1;
        load_valid = 1'b1;
        load_value = 4'd5;
        tick();
        load_valid = 1'b0;
        checks++;
        if (count !== 4'd5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_load: count %0d busy %b want 5 1", count, busy);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (tc === 1'b1) tc_at = i;
            checks++;
            if (act !== exp || count !== 4'(5 - i)) begin
                errors++;
                $display("FAIL oneshot step %0d: got %b want %b", i, act, exp);
            end
        end
        checks++;
        if (tc_at != 5 || done !== 1'b1 || busy !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_end: tc_at %0d done %b busy %b rdy %b want 5 1 0 1",
                     tc_at, done, busy, load_ready);
        end
        tick();
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_single_tc: tc %b want 0", tc);
        end
    endtask

    task automatic test_auto_reload();
        int pulses;
        pulses = 0;
        enable = 1'b1;
        auto_reload = 1'b1;
        load_valid = 1'b1;
        load_value = 4'd3;
        tick();
        load_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (tc === 1'b1) pulses++;
            checks++;
            if (act !== exp || busy !== 1'b1 || tc !== (i % 3 == 0)) begin
                errors++;
                $display("FAIL reload step %0d: got %b want %b", i, act, exp);
            end
        end
        checks++;
        if (pulses != 4) begin
            errors++;
            $display("FAIL reload_pulses: got %0d want 4", pulses);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        auto_reload = 1'b0;
    endtask

    task automatic test_enable_gap();
        bit en_pat [6] = '{1, 0, 0, 1, 1, 1};
        int tc_at;
        tc_at = -1;
        enable = 1'b1;
        load_valid = 1'b1;
        load_value = 4'd4;
        tick();
        load_valid = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            enable = en_pat[i-1];
            tick();
            if (tc === 1'b1) tc_at = i;
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL gap step %0d: got %b want %b", i, act, exp);
            end
        end
        checks++;
        if (tc_at != 6) begin
            errors++;
            $display("FAIL gap_tc_time: got %0d want 6", tc_at);
        end
    endtask

    task automatic test_abort();
        bit done_before;
        enable = 1'b1;
        load_valid = 1'b1;
        load_value = 4'd9;
        tick();
        load_valid = 1'b0;
        repeat (3) tick();
        done_before = done;
        checks++;
        if (count !== 4'd6) begin
            errors++;
            $display("FAIL abort_pre: count %0d want 6", count);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (act !== exp || count !== 4'd0 || busy !== 1'b0 || tc !== 1'b0
            || done !== done_before) begin
            errors++;
            $display("FAIL abort: got %b want %b", act, exp);
        end
        load_valid = 1'b1;
        load_value = 4'd2;
        tick();
        load_valid = 1'b0;
        checks++;
        if (count !== 4'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_reload: count %0d busy %b want 2 1", count, busy);
        end
        repeat (2) tick();
        checks++;
        if (act !== exp || tc !== 1'b1) begin
            errors++;
            $display("FAIL abort_rerun: got %b want %b", act, exp);
        end
    endtask

    task automatic test_zero_and_clr();
        done_clr = 1'b1;
        tick();
        done_clr = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_clr: done %b want 0", done);
        end
        load_valid = 1'b1;
        load_value = 4'd0;
        auto_reload = 1'b1;
        tick();
        load_valid = 1'b0;
        checks++;
        if (tc !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || act !== exp) begin
            errors++;
            $display("FAIL zero_load: got %b want %b", act, exp);
        end
        tick();
        checks++;
        if (tc !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_after: tc %b busy %b want 0 0", tc, busy);
        end
        enable = 1'b1;
        load_valid = 1'b1;
        load_value = 4'd1;
        tick();
        load_valid = 1'b0;
        done_clr = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (act !== exp || tc !== 1'b1 || done !== 1'b1 || count !== 4'd1) begin
                errors++;
                $display("FAIL clr_vs_tc %0d: got %b want %b", i, act, exp);
            end
        end
        done_clr = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        auto_reload = 1'b0;
    endtask

    task automatic test_async_reset();
        enable = 1'b1;
        load_valid = 1'b1;
        load_value = 4'd10;
        tick();
        for (int i = 1; i <= 3; i++) begin
            load_value = 4'($urandom_range(1, 15));
            tick();
            checks++;
            if (act !== exp || load_ready !== 1'b0) begin
                errors++;
                $display("FAIL run_load_ignored %0d: got %b want %b", i, act, exp);
            end
        end
        load_valid = 1'b0;
        checks++;
        if (count !== 4'd7) begin
            errors++;
            $display("FAIL reset_pre: count %0d want 7", count);
        end
        #2 reset_n = 1'b0;
        #1;
        act = {count, busy, tc, done, load_ready};
        checks++;
        if (act !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: got %b want %b", act, 8'b0000_0001);
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle_inputs();
        model_reset();
        tick();
        checks++;
        if (act !== exp || tc !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got %b want %b", act, exp);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            load_valid  = ($urandom_range(0, 9) < 3);
            load_value  = 4'($urandom_range(0, 15));
            enable      = ($urandom_range(0, 3) != 0);
            auto_reload = $urandom_range(0, 1) == 1;
            abort       = ($urandom_range(0, 19) == 0);
            done_clr    = ($urandom_range(0, 9) == 0);
            tick();
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL random %0d: got %b want %b", i, act, exp);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_auto_reload();
        test_enable_gap();
        test_abort();
        test_zero_and_clr();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
